// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } loader_state_e;

  localparam int unsigned DEF_MEM_BYTES = 148;
  localparam int unsigned BYTE_W        = 8;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream (valid/ready with last qualifier) feeding the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [BYTE_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/imem_loader_csum.sv
// 8-bit running sum (mod 256) with synchronous clear and enable.
module imem_loader_csum
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] sum
);

  logic [BYTE_W-1:0] sum_r;

  // Accumulator register; clear wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r <= 8'h00;
    end else if (clr) begin
      sum_r <= 8'h00;
    end else if (en) begin
      sum_r <= sum_r + din;
    end else begin
      sum_r <= sum_r;
    end
  end

  assign sum = sum_r;

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into the byte-wide instruction memory and holds the CPU
// in reset until a complete word-aligned image is present. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.slave        s,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [BYTE_W-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]   byte_count,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  localparam logic [ADDR_W-1:0] MAX_COUNT = ADDR_W'(MEM_BYTES);

  loader_state_e     state_r;
  loader_state_e     state_n_s;
  logic              acc_s;
  logic              wr_s;
  logic              clr_s;
  logic              release_s;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [BYTE_W-1:0] mem_wdata_r;
  logic [ADDR_W-1:0] byte_count_r;
  logic              cpu_hold_r;
  logic              done_r;
  logic              error_r;

  assign s.s_ready = (state_r == LOAD);
  assign acc_s     = s.s_valid && (state_r == LOAD);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum_s;

  imem_loader_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .en    (wr_s),
    .din   (s.s_data),
    .sum   (sum_s)
  );
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state and write/clear decisions.
  always_comb begin
    state_n_s = state_r;
    wr_s      = 1'b0;
    clr_s     = 1'b0;
    case (state_r)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_n_s = LOAD;
          clr_s     = 1'b1;
        end else begin
          state_n_s = state_r;
        end
      end
      LOAD: begin
        if (acc_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          // The last byte carries the checksum and is never stored.
          if (s.s_last) begin
            if ((sum_s == s.s_data) && (byte_count_r[1:0] == 2'b00)) begin
              state_n_s = DONE;
            end else begin
              state_n_s = ERROR;
            end
          end else if (byte_count_r < MAX_COUNT) begin
            wr_s = 1'b1;
          end else begin
            state_n_s = ERROR;
          end
`else
          if (byte_count_r < MAX_COUNT) begin
            wr_s = 1'b1;
            if (s.s_last) begin
              // count+1 is a multiple of 4 exactly when the low bits are 3
              if (byte_count_r[1:0] == 2'b11) begin
                state_n_s = DONE;
              end else begin
                state_n_s = ERROR;
              end
            end else begin
              state_n_s = LOAD;
            end
          end else begin
            state_n_s = ERROR;
          end
`endif
        end else begin
          state_n_s = LOAD;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // Status reflects a settled DONE/ERROR; leaving either on start reasserts hold at once.
  assign release_s = (state_r == DONE) && (state_n_s == DONE);

  // Registered write port, byte counter and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 8'h00;
      byte_count_r <= '0;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      mem_we_r <= wr_s;
      if (wr_s) begin
        mem_addr_r  <= byte_count_r;
        mem_wdata_r <= s.s_data;
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
      if (clr_s) begin
        byte_count_r <= '0;
      end else if (wr_s) begin
        byte_count_r <= byte_count_r + ADDR_W'(1);
      end else begin
        byte_count_r <= byte_count_r;
      end
      cpu_hold_r <= !release_s;
      done_r     <= release_s;
      error_r    <= (state_r == ERROR) && (state_n_s == ERROR);
    end
  end

  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign byte_count = byte_count_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule
